// File: rtl/psum_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : psum_pkg
//  Purpose  : Shared constants, tile type and FSM encoding for the partial-sum
//             accumulation buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package psum_pkg;

    localparam int N_ELEM = 36;
    localparam int ELEM_W = 12;
    localparam int TILE_W = N_ELEM * ELEM_W;   // 432 stored bits per entry
    localparam int LINE_W = 512;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef logic [TILE_W-1:0] tile_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAIN = 2'd2
    } psum_state_e;

endpackage
`default_nettype wire

// File: rtl/psum_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : psum_regfile
//  Purpose  : DEPTH x TILE_W register array, one combinational read port and
//             one synchronous write port. The array itself is never reset.
//  Options  : PSUM_FWD_EN - write-first bypass when the read and write hit the
//             same address in the same cycle; otherwise read-first.
//  Revision : 1.0 - initial release
// ============================================================================
module psum_regfile
    import psum_pkg::*;
(
    input  logic  clock,
    input  logic  we_i,
    input  addr_t waddr_i,
    input  tile_t wdata_i,
    input  addr_t raddr_i,
    output tile_t rdata_o
);

    tile_t mem_q [DEPTH];

    // Storage update: contents are undefined until a full clear pass
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read port, optionally forwarding the word being written this cycle
    always_comb begin
        rdata_o = mem_q[raddr_i];
`ifdef PSUM_FWD_EN
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_o = wdata_i;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/psum_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : psum_buffer
//  Purpose  : Partial-sum tile memory behind the CIM adder. Serves 1-cycle
//             pipelined CIM reads, absorbs write-backs, zeroes all entries in
//             CLEAR and streams every entry out over valid/ready in DRAIN.
//  Options  : PSUM_FWD_EN - same-cycle read-after-write bypass (in regfile).
//  Revision : 1.0 - initial release
// ============================================================================
module psum_buffer
    import psum_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              drain_start_i,
    input  logic              rd_req_i,
    input  logic [7:0]        rd_addr_i,
    input  logic              wr_valid_i,
    input  logic [7:0]        wr_addr_i,
    input  logic [LINE_W-1:0] wr_data_i,
    output logic [LINE_W-1:0] memory_data_o,
    output logic [7:0]        memory_addr_o,
    output logic              memory_valid_o,
    output logic [LINE_W-1:0] drain_data_o,
    output logic [7:0]        drain_addr_o,
    output logic              drain_valid_o,
    input  logic              drain_ready_i,
    output logic              busy_o,
    output logic              drain_done_o
);

    localparam addr_t LAST_ADDR = addr_t'(DEPTH - 1);

    psum_state_e state_q, state_d;
    addr_t       cnt_q, cnt_d;
    tile_t       mem_data_q, mem_data_d;
    addr_t       mem_addr_q, mem_addr_d;
    logic        mem_valid_q, mem_valid_d;
    tile_t       drain_data_q, drain_data_d;
    addr_t       drain_addr_q, drain_addr_d;
    logic        drain_valid_q, drain_valid_d;
    logic        done_q, done_d;

    logic        rf_we;
    addr_t       rf_waddr;
    tile_t       rf_wdata;
    addr_t       rf_raddr;
    tile_t       rf_rdata;
    logic        handshake;
    logic        unused_line_hi;

    // Upper bus bits are never stored
    assign unused_line_hi = ^wr_data_i[LINE_W-1:TILE_W];

    psum_regfile u_regfile (
        .clock   (clock),
        .we_i    (rf_we),
        .waddr_i (rf_waddr),
        .wdata_i (rf_wdata),
        .raddr_i (rf_raddr),
        .rdata_o (rf_rdata)
    );

    // Next-state, array port steering and output register loads
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_data_d    = mem_data_q;
        mem_addr_d    = mem_addr_q;
        mem_valid_d   = 1'b0;
        drain_data_d  = drain_data_q;
        drain_addr_d  = drain_addr_q;
        drain_valid_d = drain_valid_q;
        done_d        = 1'b0;
        rf_we         = 1'b0;
        rf_waddr      = wr_addr_i;
        rf_wdata      = wr_data_i[TILE_W-1:0];
        rf_raddr      = rd_addr_i;
        handshake     = drain_valid_q && drain_ready_i;

        case (state_q)
            IDLE: begin
                rf_we = wr_valid_i;
                if (rd_req_i) begin
                    mem_valid_d = 1'b1;
                    mem_addr_d  = rd_addr_i;
                    mem_data_d  = rf_rdata;
                end
                // clear has priority; a simultaneous drain request is dropped
                if (clear_i) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else if (drain_start_i) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                rf_we    = 1'b1;
                rf_waddr = cnt_q;
                rf_wdata = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + addr_t'(1);
                end
            end
            DRAIN: begin
                if (!drain_valid_q) begin
                    // first beat: fetch entry cnt into the output register
                    rf_raddr      = cnt_q;
                    drain_data_d  = rf_rdata;
                    drain_addr_d  = cnt_q;
                    drain_valid_d = 1'b1;
                end else if (handshake) begin
                    if (cnt_q == LAST_ADDR) begin
                        drain_valid_d = 1'b0;
                        done_d        = 1'b1;
                        state_d       = IDLE;
                        cnt_d         = '0;
                    end else begin
                        // prefetch the following entry so ready-high runs at full rate
                        cnt_d        = cnt_q + addr_t'(1);
                        rf_raddr     = cnt_q + addr_t'(1);
                        drain_data_d = rf_rdata;
                        drain_addr_d = cnt_q + addr_t'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any pass immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            mem_data_q    <= '0;
            mem_addr_q    <= '0;
            mem_valid_q   <= 1'b0;
            drain_data_q  <= '0;
            drain_addr_q  <= '0;
            drain_valid_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_data_q    <= mem_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_valid_q   <= mem_valid_d;
            drain_data_q  <= drain_data_d;
            drain_addr_q  <= drain_addr_d;
            drain_valid_q <= drain_valid_d;
            done_q        <= done_d;
        end
    end

    assign memory_data_o  = {{(LINE_W-TILE_W){1'b0}}, mem_data_q};
    assign memory_addr_o  = mem_addr_q;
    assign memory_valid_o = mem_valid_q;
    assign drain_data_o   = {{(LINE_W-TILE_W){1'b0}}, drain_data_q};
    assign drain_addr_o   = drain_addr_q;
    assign drain_valid_o  = drain_valid_q;
    assign busy_o         = (state_q != IDLE);
    assign drain_done_o   = done_q;

endmodule
`default_nettype wire
